oled_spi_arbiter: RTL
=====================

# oled_spi_arbiter

Shares the single OLED SPI byte writer between several requesters, such as the power-up init sequencer, the frame-refresh streamer and the host command path. Each requester presents one byte plus a D/C flag and holds a level request. The arbiter grants one requester at a time using round-robin with optional burst lock. It drives the writer's WRITE_START/DATA/DC, then returns a per-requester one-cycle done pulse. It sits between the requester blocks and the SPI byte writer.

## Interface
- NUM_REQ, default 2: number of requesters, legal range 2..8.
- TIMEOUT_CYCLES, default 65535: watchdog limit in cycles, used only when the timeout feature is compiled in.
- CLK  in  1  clock.
- RST_N  in  1  asynchronous, active-low reset.
- REQ  in  NUM_REQ  per-requester level request.
- LOCK  in  NUM_REQ  per-requester burst lock; holds the grant across consecutive bytes.
- REQ_DATA  in  8*NUM_REQ  byte for requester i, on bits [8i+7:8i].
- REQ_DC  in  NUM_REQ  D/C flag per requester: 0 = command, 1 = display data.
- REQ_DONE  out  NUM_REQ  one-cycle byte acknowledge, one-hot.
- GRANT  out  NUM_REQ  current owner, one-hot; 0 when idle.
- WRITE_START  out  1  level start to the SPI writer.
- WRITE_DONE  in  1  one-cycle completion pulse from the SPI writer.
- DATA  out  8  registered byte to the writer.
- DC  out  1  registered D/C flag to the writer.
- BUSY  out  1  high whenever state is not IDLE.
- TIMEOUT_ERR  out  1  sticky watchdog error flag.

## Operation
- Reset values:
  - state = IDLE.
  - GRANT, REQ_DONE, WRITE_START, DATA, DC, BUSY, TIMEOUT_ERR all 0.
  - last-grant pointer = NUM_REQ-1, so requester 0 wins first.
- States:
  - IDLE: if any REQ is high, pick a winner.
    - If REQ[last] and LOCK[last] are both high, the winner is last (burst continues).
    - Otherwise the winner is the first requester with REQ high, searching from last+1 upward with modulo wrap.
    - Capture REQ_DATA and REQ_DC of the winner into DATA and DC, set GRANT, set WRITE_START = 1, update last, go to WRITE.
    - If no REQ is high, stay in IDLE.
  - WRITE: hold WRITE_START, DATA and DC stable.
    - On WRITE_DONE: clear WRITE_START, set REQ_DONE[winner] for one cycle, go to RELEASE.
  - RELEASE: lasts exactly one cycle, which guarantees the writer sees WRITE_START low.
    - GRANT is cleared.
    - REQ is ignored in this cycle, because the requester is still reacting to REQ_DONE.
    - Go to IDLE.
- Requester contract: on the cycle REQ_DONE is seen, the requester either drops REQ or presents its next byte and keeps REQ high.
- WRITE_DONE outside WRITE is ignored.
- A requester that drops REQ during WRITE does not abort the write. The byte was captured at grant, and REQ_DONE is still pulsed.
- REQ changing while another requester owns the writer has no effect until the next IDLE.
- Asynchronous reset mid-write returns every output to its reset value immediately. Re-arbitration starts from requester 0.

## Timing
- REQ[i] sampled high in IDLE: GRANT and WRITE_START are high after the next edge (1-cycle latency).
- WRITE_DONE sampled high in WRITE: at the next edge WRITE_START falls and REQ_DONE rises for exactly one cycle.
- Minimum overhead per byte is 3 cycles outside the writer's busy time: grant edge, done edge, RELEASE.
- A locked burst re-grants the same requester at the first IDLE cycle. There is no gap beyond RELEASE.

## Configuration
- OLED_ARB_TIMEOUT_EN defined:
  - A cycle counter runs in WRITE and is cleared on every entry to WRITE.
  - When the count reaches TIMEOUT_CYCLES without WRITE_DONE: clear WRITE_START, pulse REQ_DONE[winner], set TIMEOUT_ERR, go to RELEASE.
  - TIMEOUT_ERR stays set until reset.
  - If WRITE_DONE and the limit coincide in the same cycle, the done wins and no error is raised.
- OLED_ARB_TIMEOUT_EN undefined:
  - No counter is built.
  - TIMEOUT_ERR is tied to 0.
  - WRITE waits indefinitely.

## Structure
- Shared package oled_pkg holds:
  - the state typedef (IDLE, WRITE, RELEASE);
  - DC_CMD = 0 and DC_DATA = 1;
  - MAX_REQ = 8.
- Sub-module oled_rr_pick is combinational.
  - Inputs: REQ vector, LOCK vector, last pointer.
  - Outputs: one-hot winner and a valid flag.
- The arbiter owns all registers and the FSM.

## Test plan
- Single requester: REQ[0] = 1, REQ_DATA = 0xAE, DC = 0, writer responds after 10 cycles. Required: WRITE_START high for 10 cycles, DATA = 0xAE, DC = 0, one REQ_DONE[0] pulse, then RELEASE then IDLE.
- Round-robin, NUM_REQ = 2: both REQ held high, no LOCK. Required: grants alternate 0, 1, 0, 1, and each REQ_DONE is one cycle.
- Burst lock: requester 1 has LOCK = 1 and sends 4 bytes 0x10..0x13 while REQ[0] stays high. Required: all four bytes go out in order before requester 0 is granted.
- Abort tolerance: requester drops REQ during WRITE. Required: write completes, REQ_DONE is still pulsed, next arbitration skips that requester.
- Reset mid-write: RST_N low during WRITE. Required: all outputs 0 immediately; after release, requester 0 wins first.
- With OLED_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, writer never answers. Required: WRITE_START drops 16 cycles after grant, REQ_DONE pulses, TIMEOUT_ERR stays 1 until reset.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED SPI arbiter.
package oled_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RELEASE = 2'd2
    } oled_state_t;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;
    localparam int   MAX_REQ = 8;
    localparam int   MAX_IDX_W = 3;

    function automatic logic [MAX_IDX_W-1:0] oh_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = 3'd0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/oled_rr_pick.sv
// Combinational round-robin winner selection with burst-lock override.
module oled_rr_pick
    import oled_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] lock_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] winner_o,
    output logic               valid_o
);

    // Locked owner keeps the writer; otherwise search upward from last+1 with wrap.
    always_comb begin
        int idx;
        idx      = 0;
        winner_o = '0;
        valid_o  = 1'b0;
        if (req_i[last_i] && lock_i[last_i]) begin
            winner_o[last_i] = 1'b1;
            valid_o          = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (int'(last_i) + k) % NUM_REQ;
                if (!valid_o && req_i[idx]) begin
                    winner_o[idx] = 1'b1;
                    valid_o       = 1'b1;
                end else begin
                    valid_o = valid_o;
                end
            end
        end
    end

endmodule

// File: rtl/oled_spi_arbiter.sv
// Round-robin arbiter sharing one OLED SPI byte writer among NUM_REQ requesters.
// Optional write watchdog is compiled in with OLED_ARB_TIMEOUT_EN.
module oled_spi_arbiter
    import oled_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NUM_REQ-1:0]   REQ,
    input  logic [NUM_REQ-1:0]   LOCK,
    input  logic [8*NUM_REQ-1:0] REQ_DATA,
    input  logic [NUM_REQ-1:0]   REQ_DC,
    output logic [NUM_REQ-1:0]   REQ_DONE,
    output logic [NUM_REQ-1:0]   GRANT,
    output logic                 WRITE_START,
    input  logic                 WRITE_DONE,
    output logic [7:0]           DATA,
    output logic                 DC,
    output logic                 BUSY,
    output logic                 TIMEOUT_ERR
);

    localparam int IDX_W = $clog2(NUM_REQ);

    oled_state_t        state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               start_q, start_d;
    logic [7:0]         data_q, data_d;
    logic               dc_q, dc_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic               busy_q;

    logic [NUM_REQ-1:0] pick_oh_s;
    logic               pick_valid_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               timeout_hit_s;

    oled_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i    (REQ),
        .lock_i   (LOCK),
        .last_i   (last_q),
        .winner_o (pick_oh_s),
        .valid_o  (pick_valid_s)
    );

    assign pick_idx_s = IDX_W'(oh_to_idx(MAX_REQ'(pick_oh_s)));

`ifdef OLED_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign timeout_hit_s = (state_q == WRITE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog count is zero outside WRITE, so every entry to WRITE starts fresh.
    always_comb begin
        cnt_d = '0;
        err_d = err_q;
        if ((state_q == WRITE) && !timeout_hit_s) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = '0;
        end
        if (timeout_hit_s && !WRITE_DONE) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Watchdog counter and sticky error register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign TIMEOUT_ERR = err_q;
`else
    assign timeout_hit_s = 1'b0;
    assign TIMEOUT_ERR   = 1'b0;
`endif

    // FSM next-state and output decode.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        start_d = start_q;
        data_d  = data_q;
        dc_d    = dc_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    grant_d = pick_oh_s;
                    data_d  = REQ_DATA[8*pick_idx_s +: 8];
                    dc_d    = REQ_DC[pick_idx_s];
                    start_d = 1'b1;
                    last_d  = pick_idx_s;
                    state_d = WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                // A done in the same cycle as the watchdog limit counts as a normal completion.
                if (WRITE_DONE || timeout_hit_s) begin
                    start_d = 1'b0;
                    done_d  = grant_q;
                    state_d = RELEASE;
                end else begin
                    state_d = WRITE;
                end
            end
            RELEASE: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                start_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; last pointer resets so requester 0 wins first.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
            data_q  <= 8'h00;
            dc_q    <= DC_CMD;
            last_q  <= IDX_W'(NUM_REQ - 1);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            start_q <= start_d;
            data_q  <= data_d;
            dc_q    <= dc_d;
            last_q  <= last_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign GRANT       = grant_q;
    assign REQ_DONE    = done_q;
    assign WRITE_START = start_q;
    assign DATA        = data_q;
    assign DC          = dc_q;
    assign BUSY        = busy_q;

endmodule
